int_issue_read: RTL and testbench

Two-stage integer issue/operand-read pipeline sitting directly downstream of the integer issue queue. Accepts one dequeued instruction per cycle, reads its two source operands from the physical register file, bypasses same-cycle writeback results, and presents a fully resolved operand packet to the integer ALU. It kills in-flight instructions younger than a ROB flush point.

---
 rtl/int_issue_read.sv | 155 +++++++++++++++
 tb/tb_int_issue_read.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_read.sv
// Two-stage integer issue/operand-read pipeline: S0 reads the PRF, S1 presents resolved operands to the ALU.
// Optional macro INT_ISSUE_BYPASS_EN adds same-cycle writeback bypass on both sources.
module int_issue_read #(
    parameter int DATA_W   = 128,
    parameter int PREG_W   = 6,
    parameter int XLEN     = 64,
    parameter int ROBID_W  = 7,
    parameter int PRS1_LSB = 111,
    parameter int PRS2_LSB = 105
) (
    input  logic               clock,
    input  logic               reset_n,

    input  logic               isq_deq_valid,
    output logic               isq_deq_ready,
    input  logic [DATA_W-1:0]  isq_deq_data,
    input  logic [ROBID_W-1:0] isq_deq_robid,

    output logic [PREG_W-1:0]  prf_rd0_addr,
    output logic [PREG_W-1:0]  prf_rd1_addr,
    input  logic [XLEN-1:0]    prf_rd0_data,
    input  logic [XLEN-1:0]    prf_rd1_data,

    input  logic               writeback0_valid,
    input  logic               writeback0_need_to_wb,
    input  logic [PREG_W-1:0]  writeback0_prd,
    input  logic [XLEN-1:0]    writeback0_data,
    input  logic               writeback1_valid,
    input  logic               writeback1_need_to_wb,
    input  logic [PREG_W-1:0]  writeback1_prd,
    input  logic [XLEN-1:0]    writeback1_data,

    input  logic               flush_valid,
    input  logic [ROBID_W-1:0] flush_robid,

    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [DATA_W-1:0]  alu_data,
    output logic [ROBID_W-1:0] alu_robid,
    output logic [XLEN-1:0]    alu_src1,
    output logic [XLEN-1:0]    alu_src2
);

    logic               s0_valid;
    logic [DATA_W-1:0]  s0_data;
    logic [ROBID_W-1:0] s0_robid;
    logic [PREG_W-1:0]  s0_prs1;
    logic [PREG_W-1:0]  s0_prs2;

    logic               s1_free;
    logic               s0_adv;
    logic               isq_accept;
    logic               kill_s0;
    logic               kill_s1;
    logic               drop_in;
    logic [XLEN-1:0]    src1_res;
    logic [XLEN-1:0]    src2_res;

    // Wrap-aware age compare: a differing MSB means one side has wrapped.
    function automatic logic is_younger(input logic [ROBID_W-1:0] a,
                                        input logic [ROBID_W-1:0] f);
        if (a[ROBID_W-1] != f[ROBID_W-1])
            return a[ROBID_W-2:0] < f[ROBID_W-2:0];
        else
            return a[ROBID_W-2:0] > f[ROBID_W-2:0];
    endfunction

    assign s0_prs1 = s0_data[PRS1_LSB +: PREG_W];
    assign s0_prs2 = s0_data[PRS2_LSB +: PREG_W];

    assign prf_rd0_addr = s0_valid ? s0_prs1 : '0;
    assign prf_rd1_addr = s0_valid ? s0_prs2 : '0;

    assign s1_free       = !alu_valid || alu_ready;
    assign s0_adv        = s0_valid && s1_free;
    assign isq_deq_ready = !s0_valid || s0_adv;
    assign isq_accept    = isq_deq_valid && isq_deq_ready;

    assign kill_s0 = flush_valid && s0_valid  && is_younger(s0_robid, flush_robid);
    assign kill_s1 = flush_valid && alu_valid && is_younger(alu_robid, flush_robid);
    assign drop_in = flush_valid && is_younger(isq_deq_robid, flush_robid);

`ifdef INT_ISSUE_BYPASS_EN
    logic wb0_fire;
    logic wb1_fire;

    assign wb0_fire = writeback0_valid && writeback0_need_to_wb && (writeback0_prd != '0);
    assign wb1_fire = writeback1_valid && writeback1_need_to_wb && (writeback1_prd != '0);

    // Port 0 takes priority over port 1 when both target the same register.
    always_comb begin
        src1_res = prf_rd0_data;
        src2_res = prf_rd1_data;
        if (s0_prs1 == '0)
            src1_res = '0;
        else if (wb0_fire && (writeback0_prd == s0_prs1))
            src1_res = writeback0_data;
        else if (wb1_fire && (writeback1_prd == s0_prs1))
            src1_res = writeback1_data;

        if (s0_prs2 == '0)
            src2_res = '0;
        else if (wb0_fire && (writeback0_prd == s0_prs2))
            src2_res = writeback0_data;
        else if (wb1_fire && (writeback1_prd == s0_prs2))
            src2_res = writeback1_data;
    end
`else
    // Without bypass the ISQ delays wakeup a cycle, so the PRF is always current.
    logic unused_wb;
    assign unused_wb = ^{writeback0_valid, writeback0_need_to_wb, writeback0_prd, writeback0_data,
                         writeback1_valid, writeback1_need_to_wb, writeback1_prd, writeback1_data};

    always_comb begin
        src1_res = (s0_prs1 == '0) ? '0 : prf_rd0_data;
        src2_res = (s0_prs2 == '0) ? '0 : prf_rd1_data;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_robid <= '0;
        end else if (isq_accept) begin
            s0_valid <= !drop_in;
            s0_data  <= isq_deq_data;
            s0_robid <= isq_deq_robid;
        end else if (s0_adv || kill_s0) begin
            s0_valid <= 1'b0;
        end
    end

    // A killed S0 never lands in S1; a stalled S1 can still be killed in place.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_valid <= 1'b0;
            alu_data  <= '0;
            alu_robid <= '0;
            alu_src1  <= '0;
            alu_src2  <= '0;
        end else if (s0_adv) begin
            alu_valid <= !kill_s0;
            if (!kill_s0) begin
                alu_data  <= s0_data;
                alu_robid <= s0_robid;
                alu_src1  <= src1_res;
                alu_src2  <= src2_res;
            end
        end else if (alu_ready || kill_s1) begin
            alu_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_issue_read.sv
// Scoreboard bench for int_issue_read: expected packets are queued at issue and popped on ALU handshakes.
module tb_int_issue_read;

    localparam int DATA_W  = 128;
    localparam int PREG_W  = 6;
    localparam int XLEN    = 64;
    localparam int ROBID_W = 7;
`ifdef INT_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               isq_deq_valid = 1'b0;
    logic               isq_deq_ready;
    logic [DATA_W-1:0]  isq_deq_data = '0;
    logic [ROBID_W-1:0] isq_deq_robid = '0;
    logic [PREG_W-1:0]  prf_rd0_addr, prf_rd1_addr;
    logic [XLEN-1:0]    prf_rd0_data, prf_rd1_data;
    logic               writeback0_valid = 1'b0, writeback0_need_to_wb = 1'b0;
    logic [PREG_W-1:0]  writeback0_prd = '0;
    logic [XLEN-1:0]    writeback0_data = '0;
    logic               writeback1_valid = 1'b0, writeback1_need_to_wb = 1'b0;
    logic [PREG_W-1:0]  writeback1_prd = '0;
    logic [XLEN-1:0]    writeback1_data = '0;
    logic               flush_valid = 1'b0;
    logic [ROBID_W-1:0] flush_robid = '0;
    logic               alu_valid;
    logic               alu_ready = 1'b1;
    logic [DATA_W-1:0]  alu_data;
    logic [ROBID_W-1:0] alu_robid;
    logic [XLEN-1:0]    alu_src1, alu_src2;

    logic [XLEN-1:0] prf [64];
    assign prf_rd0_data = prf[prf_rd0_addr];
    assign prf_rd1_data = prf[prf_rd1_addr];

    int_issue_read dut (
        .clock(clock), .reset_n(reset_n),
        .isq_deq_valid(isq_deq_valid), .isq_deq_ready(isq_deq_ready),
        .isq_deq_data(isq_deq_data), .isq_deq_robid(isq_deq_robid),
        .prf_rd0_addr(prf_rd0_addr), .prf_rd1_addr(prf_rd1_addr),
        .prf_rd0_data(prf_rd0_data), .prf_rd1_data(prf_rd1_data),
        .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
        .writeback0_prd(writeback0_prd), .writeback0_data(writeback0_data),
        .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
        .writeback1_prd(writeback1_prd), .writeback1_data(writeback1_data),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data),
        .alu_robid(alu_robid), .alu_src1(alu_src1), .alu_src2(alu_src2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ROBID_W-1:0] robid;
        logic [DATA_W-1:0]  data;
        logic [XLEN-1:0]    src1;
        logic [XLEN-1:0]    src2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [DATA_W-1:0] make_pkt(input logic [PREG_W-1:0] p1,
                                                   input logic [PREG_W-1:0] p2);
        logic [DATA_W-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[111 +: PREG_W] = p1;
        d[105 +: PREG_W] = p2;
        return d;
    endfunction

    task automatic push_exp(input logic [ROBID_W-1:0] rid, input logic [DATA_W-1:0] d,
                            input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2);
        exp_t e;
        e.robid = rid; e.data = d; e.src1 = s1; e.src2 = s2;
        sb.push_back(e);
    endtask

    // Holds the offer until a handshake edge; returns just after that edge with valid still high.
    task automatic offer(input logic [ROBID_W-1:0] rid, input logic [DATA_W-1:0] d);
        int n;
        isq_deq_valid = 1'b1;
        isq_deq_robid = rid;
        isq_deq_data  = d;
        n = 0;
        @(negedge clock);
        while (!isq_deq_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!isq_deq_ready) chk("offer_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (reset_n && alu_valid && alu_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_robid", alu_robid, e.robid);
                chk("out_data",  alu_data,  e.data);
                chk("out_src1",  alu_src1,  e.src1);
                chk("out_src2",  alu_src2,  e.src2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] d, da, db, dc;
        logic [XLEN-1:0]   a_src1, new7;

        for (int i = 0; i < 64; i++) prf[i] = 64'h1000_0000_0000_0000 + 64'(i * 3);
        prf[0] = 64'h99;
        prf[3] = 64'h11;
        prf[4] = 64'h22;

        // reset values
        #12;
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_isq_ready", isq_deq_ready, 1);
        chk("rst_alu_data",  alu_data, 0);
        chk("rst_alu_robid", alu_robid, 0);
        chk("rst_alu_src1",  alu_src1, 0);
        chk("rst_alu_src2",  alu_src2, 0);
        chk("rst_prf_addr0", prf_rd0_addr, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // basic issue with 2-cycle latency
        d = make_pkt(6'd3, 6'd4);
        push_exp(7'd5, d, 64'h11, 64'h22);
        offer(7'd5, d);
        isq_deq_valid = 1'b0;
        @(negedge clock);
        chk("lat_s0_only", alu_valid, 0);
        chk("lat_ready0", isq_deq_ready, 1);
        chk("lat_addr0", prf_rd0_addr, 3);
        chk("lat_addr1", prf_rd1_addr, 4);
        @(negedge clock);
        chk("lat_alu_valid", alu_valid, 1);
        chk("lat_ready1", isq_deq_ready, 1);
        wait_drain();

        // bypass priority: port 0 beats port 1
        d = make_pkt(6'd3, 6'd4);
        push_exp(7'd6, d, BYP ? 64'hAA : 64'h11, 64'h22);
        offer(7'd6, d);
        isq_deq_valid = 1'b0;
        writeback0_valid = 1; writeback0_need_to_wb = 1; writeback0_prd = 3; writeback0_data = 64'hAA;
        writeback1_valid = 1; writeback1_need_to_wb = 1; writeback1_prd = 3; writeback1_data = 64'hBB;
        @(posedge clock); #1;
        writeback0_valid = 0; writeback1_valid = 0;
        wait_drain();

        // need_to_wb low on port 0 disqualifies it; port 1 supplies src2
        d = make_pkt(6'd3, 6'd4);
        push_exp(7'd7, d, 64'h11, BYP ? 64'hCC : 64'h22);
        offer(7'd7, d);
        isq_deq_valid = 1'b0;
        writeback0_valid = 1; writeback0_need_to_wb = 0; writeback0_prd = 4; writeback0_data = 64'h77;
        writeback1_valid = 1; writeback1_need_to_wb = 1; writeback1_prd = 4; writeback1_data = 64'hCC;
        @(posedge clock); #1;
        writeback0_valid = 0; writeback1_valid = 0;
        wait_drain();

        // preg 0 always reads as zero
        d = make_pkt(6'd0, 6'd0);
        push_exp(7'd8, d, 64'h0, 64'h0);
        offer(7'd8, d);
        isq_deq_valid = 1'b0;
        writeback0_valid = 1; writeback0_need_to_wb = 1; writeback0_prd = 0; writeback0_data = 64'h55;
        @(posedge clock); #1;
        writeback0_valid = 0;
        wait_drain();

        // back-to-back throughput
        for (int k = 0; k < 4; k++) begin
            logic [PREG_W-1:0] p1, p2;
            p1 = PREG_W'($urandom_range(1, 63));
            p2 = PREG_W'($urandom_range(1, 63));
            d = make_pkt(p1, p2);
            push_exp(7'(40 + k), d, prf[p1], prf[p2]);
            offer(7'(40 + k), d);
        end
        isq_deq_valid = 1'b0;
        wait_drain();

        // stall: S1 holds A, S0 holds B and re-reads the PRF
        alu_ready = 1'b0;
        da = make_pkt(6'd5, 6'd6);
        db = make_pkt(6'd7, 6'd8);
        dc = make_pkt(6'd9, 6'd10);
        a_src1 = prf[5];
        push_exp(7'd10, da, prf[5], prf[6]);
        push_exp(7'd11, db, prf[7], prf[8]);
        push_exp(7'd12, dc, prf[9], prf[10]);
        offer(7'd10, da);
        offer(7'd11, db);
        isq_deq_robid = 7'd12; isq_deq_data = dc;
        @(negedge clock);
        chk("stall_ready", isq_deq_ready, 0);
        chk("stall_s1_robid", alu_robid, 10);
        chk("stall_s0_addr", prf_rd0_addr, 7);
        new7 = 64'hDEAD_0007;
        prf[7] = new7;
        sb[1].src1 = new7;
        repeat (2) begin
            @(negedge clock);
            chk("stall_hold_valid", alu_valid, 1);
            chk("stall_hold_robid", alu_robid, 10);
            chk("stall_hold_src1", alu_src1, a_src1);
            chk("stall_hold_ready", isq_deq_ready, 0);
        end
        @(posedge clock); #1;
        alu_ready = 1'b1;
        offer(7'd12, dc);
        isq_deq_valid = 1'b0;
        wait_drain();

        // flush: S1 0x7E survives, S0 0x01 (wrapped, younger) dies
        alu_ready = 1'b0;
        d = make_pkt(6'd11, 6'd12);
        push_exp(7'h7E, d, prf[11], prf[12]);
        offer(7'h7E, d);
        offer(7'h01, make_pkt(6'd13, 6'd14));
        isq_deq_robid = 7'h02;
        isq_deq_data  = make_pkt(6'd15, 6'd16);
        flush_valid = 1'b1; flush_robid = 7'h7E;
        @(negedge clock);
        chk("flush_ready_blocked", isq_deq_ready, 0);
        @(posedge clock); #1;
        flush_valid = 1'b0; isq_deq_valid = 1'b0;
        @(negedge clock);
        chk("flush_s1_kept", alu_valid, 1);
        chk("flush_s1_robid", alu_robid, 7'h7E);
        chk("flush_s0_empty", isq_deq_ready, 1);
        chk("flush_s0_addr", prf_rd0_addr, 0);

        // refill S0, then flush while S0 advances and 0x02 handshakes
        @(posedge clock); #1;
        offer(7'h01, make_pkt(6'd13, 6'd14));
        isq_deq_robid = 7'h02;
        isq_deq_data  = make_pkt(6'd15, 6'd16);
        flush_valid = 1'b1; flush_robid = 7'h7E;
        alu_ready = 1'b1;
        @(negedge clock);
        chk("flush2_ready", isq_deq_ready, 1);
        @(posedge clock); #1;
        flush_valid = 1'b0; isq_deq_valid = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("flush2_no_out", alu_valid, 0);
        end
        chk("flush2_sb_empty", sb.size(), 0);
        @(posedge clock); #1;

        // asynchronous reset with both stages full
        alu_ready = 1'b0;
        offer(7'd20, make_pkt(6'd1, 6'd2));
        offer(7'd21, make_pkt(6'd3, 6'd4));
        isq_deq_valid = 1'b0;
        @(negedge clock);
        chk("pre_rst_valid", alu_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", alu_valid, 0);
        chk("async_rst_ready", isq_deq_ready, 1);
        chk("async_rst_robid", alu_robid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        alu_ready = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("post_rst_no_out", alu_valid, 0);
        end
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
